// File: rtl/ni_packetizer.sv
// ni_packetizer: network-interface transmitter feeding a router local input port.
// Turns a packet request (destination, word count) plus a data-word stream into
// the flit sequence HEADER, PAYLOAD..., TAIL. A zero-length packet becomes
// HEADER followed by an all-zero TAIL.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cur_addr_rst              own node address, sampled while rst is low
//   pkt_valid/pkt_ready       packet request handshake (pkt_dst, pkt_len)
//   data_valid/data_ready     data word handshake (data_in)
//   flit_out/flit_valid       output flit register toward the router
//   router_full               router local buffer full (back-pressure)
//   busy                      packet in progress or flit still pending
//   pkt_cnt, flit_cnt         only with NI_STATS_EN: TAIL / flit transfer counts
//
// Build options:
//   NI_STATS_EN   adds the pkt_cnt/flit_cnt statistics outputs.
//   NODES, HEADER, PAYLOAD, TAIL get defaults below unless defined externally.

`ifndef NODES
`define NODES 8
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

module ni_packetizer #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned ADDR_W = `NODES / 2,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cur_addr_rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [ADDR_W-1:0] pkt_dst,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [FLIT_W-4:0] data_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              router_full,
`ifdef NI_STATS_EN
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       flit_cnt,
`endif
  output logic              busy
);

  localparam int unsigned DataW = FLIT_W - 3;

  typedef enum logic [1:0] {StIdle, StData, StZtail} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [ADDR_W-1:0]  src_addr_q;
  logic [FLIT_W-1:0]  header;
  logic               xfer;
  logic               can_load;
  logic               last_word;

  // The output register may reload when empty or when it empties this edge.
  assign xfer      = flit_valid & ~router_full;
  assign can_load  = ~flit_valid | ~router_full;
  assign last_word = (remaining_q == LEN_W'(1));

  // Readies are forced low while reset is held.
  assign pkt_ready  = rst & (state_q == StIdle) & can_load;
  assign data_ready = rst & (state_q == StData) & can_load;
  assign busy       = (state_q != StIdle) | flit_valid;

  always_comb begin
    header                                = '0;
    header[FLIT_W-1 -: 3]                 = `HEADER;
    header[2*ADDR_W+LEN_W-1 -: LEN_W]     = pkt_len;
    header[2*ADDR_W-1 -: ADDR_W]          = src_addr_q;
    header[ADDR_W-1:0]                    = pkt_dst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      flit_out    <= '0;
      flit_valid  <= 1'b0;
      remaining_q <= '0;
      // Own address is loaded for as long as reset is held.
      src_addr_q  <= cur_addr_rst;
    end else begin
      if (xfer) begin
        flit_valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (pkt_valid && pkt_ready) begin
            flit_out    <= header;
            flit_valid  <= 1'b1;
            remaining_q <= pkt_len;
            state_q     <= (pkt_len == '0) ? StZtail : StData;
          end
        end
        StData: begin
          if (data_valid && data_ready) begin
            flit_out    <= {(last_word ? `TAIL : `PAYLOAD), data_in};
            flit_valid  <= 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (last_word) begin
              state_q <= StIdle;
            end
          end
        end
        StZtail: begin
          if (can_load) begin
            flit_out   <= {`TAIL, {DataW{1'b0}}};
            flit_valid <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NI_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else if (xfer) begin
      flit_cnt <= flit_cnt + 16'd1;
      if (flit_out[FLIT_W-1 -: 3] == `TAIL) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
module tb_ni_packetizer;
  localparam int FLIT_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int LEN_W   = 4;
  localparam int ID_HDR  = 1;
  localparam int ID_PAY  = 2;
  localparam int ID_TAIL = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  cur_addr_rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dst;
  logic [3:0]  pkt_len;
  logic        data_valid;
  logic        data_ready;
  logic [28:0] data_in;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        router_full;
  logic        busy;
`ifdef NI_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] flit_cnt;
`endif

  ni_packetizer #(.FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cur_addr_rst (cur_addr_rst),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_dst      (pkt_dst),
    .pkt_len      (pkt_len),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_in      (data_in),
    .flit_out     (flit_out),
    .flit_valid   (flit_valid),
    .router_full  (router_full),
`ifdef NI_STATS_EN
    .pkt_cnt      (pkt_cnt),
    .flit_cnt     (flit_cnt),
`endif
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bp_cnt = 0;
  bit bp_rand = 0;
  int src_model = 0;
  int exp_pkts = 0;
  int exp_flits = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] hdr_f(input int len, input int src, input int dst);
    return (32'(ID_HDR) << 29) | (32'(len) << 8) | (32'(src) << 4) | 32'(dst);
  endfunction

  function automatic logic [31:0] dat_f(input int id, input logic [28:0] d);
    return (32'(id) << 29) | 32'(d);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Flit collector plus back-pressure rules, sampled on the falling edge.
  bit          hold = 0;
  logic [31:0] hold_flit;
  always @(negedge clk) begin
    if (!rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("stable_valid", 64'(flit_valid), 64'(1));
        chk("stable_flit", 64'(flit_out), 64'(hold_flit));
      end
      if (flit_valid && !router_full) begin
        got.push_back(flit_out);
        got_cyc.push_back(cyc);
      end
      if (flit_valid && router_full) begin
        chk("full_readies", 64'({pkt_ready, data_ready}), 64'(0));
        hold = 1;
        hold_flit = flit_out;
      end else begin
        hold = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (bp_cnt > 0) begin
      router_full = 1;
      bp_cnt--;
    end else begin
      router_full = bp_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  endtask

  task automatic req(input int dst, input int len, input int hold_cycles);
    bit acc = 0;
    pkt_valid = 1;
    pkt_dst = 4'(dst);
    pkt_len = 4'(len);
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = pkt_ready;
      if (acc) bp_cnt = hold_cycles;
      tick();
    end
    if (!acc) chk("req_timeout", 64'(0), 64'(1));
    pkt_valid = 0;
    exp_q.push_back(hdr_f(len, src_model, dst));
    exp_pkts++;
    exp_flits += (len == 0) ? 2 : len + 1;
    if (len == 0) exp_q.push_back(dat_f(ID_TAIL, 29'd0));
  endtask

  task automatic put_word(input logic [28:0] w, input bit last, input int gap);
    bit acc = 0;
    data_valid = 0;
    repeat (gap) tick();
    data_valid = 1;
    data_in = w;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = data_ready;
      tick();
    end
    if (!acc) chk("data_timeout", 64'(0), 64'(1));
    data_valid = 0;
    exp_q.push_back(dat_f(last ? ID_TAIL : ID_PAY, w));
  endtask

  task automatic send(input int dst, input int len, input int hold_cycles, input int maxgap,
                      input bit seq);
    req(dst, len, hold_cycles);
    for (int i = 0; i < len; i++) begin
      put_word(seq ? 29'(i + 1) : 29'($urandom), i == len - 1, $urandom_range(0, maxgap));
    end
  endtask

  task automatic drain(input bit dr_zero);
    for (int t = 0; t < 1000 && got.size() < exp_q.size(); t++) begin
      @(negedge clk);
      if (dr_zero) chk("drain_data_ready", 64'(data_ready), 64'(0));
      tick();
    end
    chk("drain_count", 64'(got.size()), 64'(exp_q.size()));
  endtask

  task automatic cmp_flush(input string tag);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [3:0] addr);
    #1;
    rst = 0;
    cur_addr_rst = addr;
    src_model = addr;
    exp_pkts = 0;
    exp_flits = 0;
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    rst = 0;
    cur_addr_rst = 4'h5;
    src_model = 5;
    pkt_valid = 0;
    pkt_dst = 0;
    pkt_len = 0;
    data_valid = 0;
    data_in = 0;
    router_full = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flit_valid", 64'(flit_valid), 64'(0));
    chk("rst_flit_out", 64'(flit_out), 64'(0));
    chk("rst_readies", 64'({pkt_ready, data_ready}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1;
    tick();

    // Single packet, consecutive flits.
    send(4'hA, 3, 0, 0, 1);
    drain(1);
    chk("single_hdr_const", 64'(exp_q[0]), 64'(32'h2000_035A));
    chk("single_span", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
    chk("single_busy", 64'(busy), 64'(0));
    cmp_flush("single");

    // Back-pressure for 4 cycles after the header appears.
    send(4'hA, 3, 4, 0, 1);
    drain(1);
    cmp_flush("backpressure");

    // Zero-length packet with stray data offered.
    data_valid = 1;
    data_in = 29'h1234567;
    req(4'h7, 0, 0);
    drain(1);
    data_valid = 0;
    cmp_flush("zero_len");

    // Back-to-back len=1 packets with no idle cycle.
    send(4'hB, 1, 0, 0, 0);
    send(4'hC, 1, 0, 0, 0);
    drain(1);
    chk("b2b_span", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
    cmp_flush("b2b");

    // Destination equal to own address; maximum length.
    send(5, 2, 0, 0, 0);
    send(4'h3, 15, 0, 0, 0);
    drain(1);
    cmp_flush("dst_self_maxlen");

    // Randomized traffic with random back-pressure and data gaps.
    bp_rand = 1;
    for (int p = 0; p < 25; p++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15), 0, 2, 0);
    end
    drain(1);
    bp_rand = 0;
    cmp_flush("random");

    // Reset in the middle of a len=3 packet while a payload is pending.
    req(4'hA, 3, 0);
    put_word(29'd1, 0, 0);
    drain(0);
    cmp_flush("pre_rst");
    put_word(29'd2, 0, 0);
    chk("pre_rst_valid", 64'(flit_valid), 64'(1));
    #1;
    rst = 0;
    cur_addr_rst = 4'h3;
    #1;
    chk("async_flit_valid", 64'(flit_valid), 64'(0));
    chk("async_flit_out", 64'(flit_out), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_readies", 64'({pkt_ready, data_ready}), 64'(0));
    do_reset(4'h3);
    cur_addr_rst = 4'h9;  // must not be picked up outside reset
    tick();
    send(4'hA, 2, 0, 0, 0);
    drain(1);
    cmp_flush("post_rst");

    // Statistics: 3 packets, 9 flits.
    do_reset(4'h6);
    tick();
    send(4'h1, 1, 0, 0, 0);
    send(4'h2, 2, 0, 0, 0);
    send(4'h3, 3, 0, 0, 0);
    drain(1);
    cmp_flush("stats_pkts");
    tick();
`ifdef NI_STATS_EN
    chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts % 65536));
    chk("flit_cnt", 64'(flit_cnt), 64'(exp_flits % 65536));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
